// File: rtl/keccak_digest_collector_if.sv
// rtl/keccak_digest_collector_if.sv - squeeze-beat stream between keccak_core and the digest collector
interface keccak_digest_collector_if #(
    parameter int DATA_W = 256
);
    logic [DATA_W-1:0]   t_data;
    logic                t_valid;
    logic                t_last;
    logic [DATA_W/8-1:0] t_keep;
    logic                t_ready;

    modport master (
        output t_data,
        output t_valid,
        output t_last,
        output t_keep,
        input  t_ready
    );

    modport slave (
        input  t_data,
        input  t_valid,
        input  t_last,
        input  t_keep,
        output t_ready
    );
endinterface

// File: rtl/keccak_digest_collector.sv
// rtl/keccak_digest_collector.sv - packs keccak squeeze beats into a digest buffer and stops the core for SHAKE
module keccak_digest_collector #(
    parameter int DATA_W        = 256,
    parameter int MAX_OUT_BYTES = 256,
    parameter int LEN_W         = 16,
    parameter int STOP_HOLD     = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_i,
    input  logic                       xof_i,
    input  logic [LEN_W-1:0]           out_len_i,
    keccak_digest_collector_if.slave   s_axis,
    output logic                       stop_o,
    output logic [MAX_OUT_BYTES*8-1:0] digest_o,
    output logic [LEN_W-1:0]           digest_len_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int AW     = $clog2(MAX_OUT_BYTES);
    localparam int HW     = $clog2(STOP_HOLD);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_STOP    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_OUT_BYTES);
    localparam logic [HW-1:0]    HOLD_END = HW'(STOP_HOLD - 1);

    logic [1:0]       state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    logic             xof_q;
    logic             err_q;
    logic [HW-1:0]    hold_cnt;
    logic [7:0]       dbuf [MAX_OUT_BYTES];

    logic [LEN_W-1:0] nbytes;
    logic [LEN_W-1:0] limit;
    logic [LEN_W-1:0] room;
    logic [LEN_W-1:0] wr_bytes;
    logic [LEN_W-1:0] next_count;
    logic             beat;
    logic             req_bad;

    // keep is contiguous from bit 0, so its popcount is the byte count of the beat
    always_comb begin
        nbytes = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            nbytes = nbytes + LEN_W'(s_axis.t_keep[i]);
        end
    end

    always_comb begin
        limit      = xof_q ? len_q : MAX_LEN;
        room       = limit - count;
        wr_bytes   = (nbytes > room) ? room : nbytes;
        next_count = count + wr_bytes;
        beat       = s_axis.t_valid && (state == S_COLLECT);
        req_bad    = xof_i && ((out_len_i == '0) || (out_len_i > MAX_LEN));
    end

    assign s_axis.t_ready = (state == S_COLLECT);
    assign stop_o         = (state == S_STOP);
    assign busy_o         = (state == S_COLLECT) || (state == S_STOP);
    assign done_o         = (state == S_DONE);
    assign err_o          = err_q;
    assign digest_len_o   = count;

    for (genvar k = 0; k < MAX_OUT_BYTES; k++) begin : g_digest
        assign digest_o[8*k +: 8] = dbuf[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            len_q    <= '0;
            xof_q    <= 1'b0;
            err_q    <= 1'b0;
            hold_cnt <= '0;
            for (int k = 0; k < MAX_OUT_BYTES; k++) begin
                dbuf[k] <= 8'h00;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (req_i) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            xof_q    <= xof_i;
                            len_q    <= out_len_i;
                            count    <= '0;
                            err_q    <= 1'b0;
                            hold_cnt <= '0;
                            for (int k = 0; k < MAX_OUT_BYTES; k++) begin
                                dbuf[k] <= 8'h00;
                            end
                            state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (beat) begin
                        // bytes beyond the remaining room are dropped, which also saturates count
                        for (int j = 0; j < KEEP_W; j++) begin
                            if (LEN_W'(j) < wr_bytes) begin
                                dbuf[AW'(count + LEN_W'(j))] <= s_axis.t_data[8*j +: 8];
                            end
                        end
                        count <= next_count;
                        if (xof_q) begin
                            if (next_count == len_q) begin
                                hold_cnt <= '0;
                                state    <= S_STOP;
                            end else if (s_axis.t_last) begin
                                err_q <= 1'b1;
                                state <= S_DONE;
                            end
                        end else begin
                            if (nbytes > room) begin
                                err_q <= 1'b1;
                            end
                            if (s_axis.t_last) begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_STOP: begin
                    // hold stop long enough for the core to finish a permutation and see it in SQUEEZE
                    if (hold_cnt == HOLD_END) begin
                        state <= S_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
